// File: rtl/dcnt_pkg.sv
// Shared types and constants for the cascaded 4-bit down-counter timer.
package dcnt_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ARMED = 3'd2,
      RUN   = 3'd3,
      HOLD  = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam int SLICE_W = 4;
   localparam logic [SLICE_W-1:0] SLICE_ZERO = '0;
   localparam logic [SLICE_W-1:0] SLICE_ONE  = SLICE_W'(1);

endpackage

// File: rtl/dcnt4_slice.sv
// Next-value function of one 4-bit loadable down-counter slice (wraps 0 -> F).
module dcnt4_slice
   import dcnt_pkg::*;
(
   input  logic [SLICE_W-1:0] cur,
   input  logic               load,
   input  logic [SLICE_W-1:0] load_val,
   input  logic               dec_en,
   output logic [SLICE_W-1:0] nxt,
   output logic               zero
);

   always_comb begin
      nxt = cur;
      if (load) begin
         nxt = load_val;
      end else if (dec_en) begin
         nxt = cur - SLICE_ONE;
      end
   end

   assign zero = (cur == SLICE_ZERO);

endmodule

// File: rtl/dcnt_cascade_ctrl.sv
// Sequencing controller for an NSLICE x 4-bit programmable interval timer:
// config handshake, load, borrow-rippled decrement, terminal count and irq.
module dcnt_cascade_ctrl
   import dcnt_pkg::*;
#(
   parameter  int NSLICE = 4,
   localparam int W      = SLICE_W * NSLICE
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic [W-1:0] cfg_reload,
   input  logic         cfg_periodic,
   input  logic         start,
   input  logic         stop,
   input  logic         pause,
   input  logic         tick_en,
   output logic [W-1:0] count,
   output logic         tc_pulse,
   output logic         busy,
   output logic         irq,
   input  logic         irq_ack
);

   state_t              state, state_nxt;
   logic [W-1:0]        count_q, count_nxt, reload_q;
   logic                periodic_q, tc_q, irq_q;
   logic                cfg_xfer, run_tick, cnt_zero, tc_evt, load_cnt;
   logic [NSLICE-1:0]   slice_zero, slice_dec;

   assign cfg_ready = (state == IDLE) || (state == DONE);
   assign busy      = (state == LOAD) || (state == ARMED) ||
                      (state == RUN)  || (state == HOLD);
   assign count     = count_q;
   assign tc_pulse  = tc_q;
   assign irq       = irq_q;

   // stop and pause both mask the tick for the cycle they are seen
   assign cfg_xfer = cfg_valid & cfg_ready;
   assign run_tick = (state == RUN) & ~stop & ~pause & tick_en;
   assign cnt_zero = &slice_zero;
   assign tc_evt   = run_tick & cnt_zero;
   assign load_cnt = ((state == LOAD) & ~stop) | (tc_evt & periodic_q);

   // A slice borrows only when every lower slice is already zero
   always_comb begin
      slice_dec    = '0;
      slice_dec[0] = run_tick & ~cnt_zero;
      for (int i = 1; i < NSLICE; i++) begin
         slice_dec[i] = slice_dec[i-1] & slice_zero[i-1];
      end
   end

   for (genvar i = 0; i < NSLICE; i++) begin : g_slice
      dcnt4_slice u_slice (
         .cur      (count_q[i*SLICE_W +: SLICE_W]),
         .load     (load_cnt),
         .load_val (reload_q[i*SLICE_W +: SLICE_W]),
         .dec_en   (slice_dec[i]),
         .nxt      (count_nxt[i*SLICE_W +: SLICE_W]),
         .zero     (slice_zero[i])
      );
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cfg_xfer) state_nxt = LOAD;
         LOAD:    state_nxt = stop ? IDLE : ARMED;
         ARMED: begin
            if (stop)       state_nxt = IDLE;
            else if (start) state_nxt = RUN;
         end
         RUN: begin
            if (stop)                      state_nxt = IDLE;
            else if (pause)                state_nxt = HOLD;
            else if (tc_evt & ~periodic_q) state_nxt = DONE;
         end
         HOLD: begin
            if (stop)        state_nxt = IDLE;
            else if (!pause) state_nxt = RUN;
         end
         DONE:    if (cfg_xfer || start) state_nxt = LOAD;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         count_q    <= '0;
         reload_q   <= '0;
         periodic_q <= 1'b0;
         tc_q       <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         state   <= state_nxt;
         count_q <= count_nxt;
         tc_q    <= tc_evt;
         if (cfg_xfer) begin
            reload_q   <= cfg_reload;
            periodic_q <= cfg_periodic;
         end
         if (tc_evt) begin
            irq_q <= 1'b1;
         end else if (irq_ack) begin
            irq_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dcnt_cascade_ctrl.sv
// Directed bench for dcnt_cascade_ctrl with a cycle-level behavioural model.
module tb_dcnt_cascade_ctrl;

   localparam int NSLICE = 4;
   localparam int W      = 4 * NSLICE;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cfg_valid = 1'b0;
   logic         cfg_ready;
   logic [W-1:0] cfg_reload = '0;
   logic         cfg_periodic = 1'b0;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic         pause = 1'b0;
   logic         tick_en = 1'b0;
   logic [W-1:0] count;
   logic         tc_pulse;
   logic         busy;
   logic         irq;
   logic         irq_ack = 1'b0;

   always #5 clk = ~clk;

   dcnt_cascade_ctrl #(.NSLICE(NSLICE)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_reload   (cfg_reload),
      .cfg_periodic (cfg_periodic),
      .start        (start),
      .stop         (stop),
      .pause        (pause),
      .tick_en      (tick_en),
      .count        (count),
      .tc_pulse     (tc_pulse),
      .busy         (busy),
      .irq          (irq),
      .irq_ack      (irq_ack)
   );

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: named phases, plain integer count arithmetic
   localparam int M_IDLE = 0, M_LOAD = 1, M_ARMED = 2, M_RUN = 3, M_HOLD = 4, M_DONE = 5;
   int           m_state  = M_IDLE;
   int unsigned  m_count  = 0;
   int unsigned  m_reload = 0;
   bit           m_per    = 1'b0;
   bit           m_tc     = 1'b0;
   bit           m_irq    = 1'b0;
   bit           m_ev;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_state = M_IDLE; m_count = 0; m_reload = 0; m_per = 0; m_tc = 0; m_irq = 0;
      end else begin
         m_ev = 1'b0;
         case (m_state)
            M_IDLE: if (cfg_valid) begin
               m_reload = cfg_reload; m_per = cfg_periodic; m_state = M_LOAD;
            end
            M_LOAD: if (stop) m_state = M_IDLE;
                    else begin m_count = m_reload; m_state = M_ARMED; end
            M_ARMED: if (stop) m_state = M_IDLE; else if (start) m_state = M_RUN;
            M_RUN: begin
               if (stop) m_state = M_IDLE;
               else if (pause) m_state = M_HOLD;
               else if (tick_en) begin
                  if (m_count == 0) begin
                     m_ev = 1'b1;
                     if (m_per) m_count = m_reload; else m_state = M_DONE;
                  end else begin
                     m_count = m_count - 1;
                  end
               end
            end
            M_HOLD: if (stop) m_state = M_IDLE; else if (!pause) m_state = M_RUN;
            M_DONE: if (cfg_valid) begin
               m_reload = cfg_reload; m_per = cfg_periodic; m_state = M_LOAD;
            end else if (start) m_state = M_LOAD;
            default: m_state = M_IDLE;
         endcase
         m_tc = m_ev;
         if (m_ev) m_irq = 1'b1; else if (irq_ack) m_irq = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("mdl_count", 32'(count), 32'(m_count));
         check("mdl_tc", 32'(tc_pulse), 32'(m_tc));
         check("mdl_irq", 32'(irq), 32'(m_irq));
         check("mdl_busy", 32'(busy), 32'(m_state >= M_LOAD && m_state <= M_HOLD));
         check("mdl_cfg_ready", 32'(cfg_ready), 32'(m_state == M_IDLE || m_state == M_DONE));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Config transfer then LOAD; returns in ARMED with the count loaded
   task automatic load_cfg(input logic [W-1:0] r, input logic p);
      cfg_valid = 1'b1; cfg_reload = r; cfg_periodic = p;
      step();
      cfg_valid = 1'b0;
      step();
   endtask

   int ntc;

   initial begin
      step();
      chk_en = 1'b1;
      step();
      check("rst_count", 32'(count), 32'h0);
      check("rst_cfg_ready", 32'(cfg_ready), 32'h1);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_tc", 32'(tc_pulse), 32'h0);
      rst_n = 1'b1;

      // one-shot, reload 3
      load_cfg(16'd3, 1'b0);
      check("os_armed_count", 32'(count), 32'd3);
      start = 1'b1; tick_en = 1'b1;
      step();
      check("os_entry_count", 32'(count), 32'd3);
      step();
      check("os_count2", 32'(count), 32'd2);
      step(); step();
      check("os_count0", 32'(count), 32'd0);
      check("os_no_tc_yet", 32'(tc_pulse), 32'h0);
      step();
      start = 1'b0;
      check("os_tc", 32'(tc_pulse), 32'h1);
      check("os_busy", 32'(busy), 32'h0);
      check("os_irq", 32'(irq), 32'h1);
      check("os_done_ready", 32'(cfg_ready), 32'h1);
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
      check("os_irq_ack", 32'(irq), 32'h0);

      // periodic, reload 2
      load_cfg(16'd2, 1'b1);
      start = 1'b1;
      step();
      start = 1'b0;
      ntc = 0;
      for (int i = 0; i < 9; i++) begin
         step();
         if (i % 3 == 2) check("per_tc", 32'(tc_pulse), 32'h1);
         ntc += int'(tc_pulse);
      end
      check("per_tc_total", 32'(ntc), 32'd3);
      check("per_reload_count", 32'(count), 32'd2);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("per_stop_ready", 32'(cfg_ready), 32'h1);

      // borrow ripple across slices
      tick_en = 1'b0;
      load_cfg(16'h0100, 1'b0);
      start = 1'b1;
      step();
      start = 1'b0; tick_en = 1'b1;
      step();
      check("brw_00ff", 32'(count), 32'h00FF);
      step();
      check("brw_00fe", 32'(count), 32'h00FE);
      check("brw_no_tc", 32'(tc_pulse), 32'h0);
      tick_en = 1'b0; stop = 1'b1;
      step();
      stop = 1'b0;

      // pause / resume / stop
      load_cfg(16'd5, 1'b0);
      start = 1'b1; tick_en = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      check("pau_count3", 32'(count), 32'd3);
      pause = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("pau_frozen", 32'(count), 32'd3);
      end
      pause = 1'b0;
      step();
      step();
      check("pau_resume", 32'(count), 32'd2);
      stop = 1'b1; tick_en = 1'b0;
      step();
      stop = 1'b0;
      check("stop_count", 32'(count), 32'd2);
      check("stop_ready", 32'(cfg_ready), 32'h1);
      check("stop_busy", 32'(busy), 32'h0);
      check("stop_no_tc", 32'(tc_pulse), 32'h0);

      // periodic reload 0 with irq_ack held: set wins
      load_cfg(16'd0, 1'b1);
      irq_ack = 1'b1; start = 1'b1; tick_en = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("z_tc", 32'(tc_pulse), 32'h1);
         check("z_irq", 32'(irq), 32'h1);
      end
      stop = 1'b1;
      step();
      stop = 1'b0; irq_ack = 1'b0;

      // reach DONE, then cfg and start together
      load_cfg(16'd1, 1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      check("dn_tc", 32'(tc_pulse), 32'h1);
      check("dn_ready", 32'(cfg_ready), 32'h1);
      cfg_valid = 1'b1; cfg_reload = 16'd7; cfg_periodic = 1'b0; start = 1'b1;
      step();
      cfg_valid = 1'b0; start = 1'b0;
      check("dn_load_busy", 32'(busy), 32'h1);
      step();
      check("dn_new_reload", 32'(count), 32'd7);
      stop = 1'b1; tick_en = 1'b0;
      step();
      stop = 1'b0;

      // reset in the middle of RUN
      load_cfg(16'h000A, 1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      check("mr_count", 32'(count), 32'h000A);
      check("mr_irq_before", 32'(irq), 32'h1);
      rst_n = 1'b0;
      step();
      check("mr_rst_count", 32'(count), 32'h0);
      check("mr_rst_irq", 32'(irq), 32'h0);
      check("mr_rst_ready", 32'(cfg_ready), 32'h1);
      check("mr_rst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      step();

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
